// File: rtl/counter_9_sched_if.sv
// -----------------------------------------------------------------------------
// counter_9_sched_if
//   Command channel of the mod-9 run scheduler.
//
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave  -> master command taken at an edge where valid && ready
//   cmd_op     master -> slave  00 START, 01 PAUSE, 10 RESUME, 11 ABORT
//   cmd_laps   master -> slave  lap target, only looked at with START (0 = free-run)
// -----------------------------------------------------------------------------
interface counter_9_sched_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_laps;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_laps,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_laps,
      output cmd_ready
   );
endinterface

// File: rtl/counter_9_sched.sv
// -----------------------------------------------------------------------------
// counter_9_sched
//   Command-driven scheduler around a mod-9 counter (q = 0..8). A START runs
//   the counter for a programmed number of full laps (or free-runs when the
//   target is 0). PAUSE/RESUME freeze and restart it. ABORT drops back to idle.
//   Commands that do not fit the current state are flagged and otherwise ignored.
//
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high, overrides everything
//   cmd      slave side of counter_9_sched_if (valid/ready/op/laps)
//   q        out  counter value 0..8
//   lap_cnt  out  completed laps of the current or last run, mod 16
//   busy     out  run in progress (RUN, PAUSE and the closing DONE cycle)
//   paused   out  state is PAUSE
//   wrap     out  one-cycle pulse when q goes 8 -> 0
//   done     out  one-cycle pulse while in DONE
//   cmd_err  out  one-cycle pulse after an illegal command was accepted
// -----------------------------------------------------------------------------
module counter_9_sched (
   input  logic                    clock,
   input  logic                    reset,
   counter_9_sched_if.slave        cmd,
   output logic [3:0]              q,
   output logic [3:0]              lap_cnt,
   output logic                    busy,
   output logic                    paused,
   output logic                    wrap,
   output logic                    done,
   output logic                    cmd_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OP_START  = 2'b00,
      OP_PAUSE  = 2'b01,
      OP_RESUME = 2'b10,
      OP_ABORT  = 2'b11
   } op_e;

   state_e     state;
   op_e        op;
   logic [3:0] target;
   logic [3:0] lap_inc;
   logic       accept;

   assign op      = op_e'(cmd.cmd_op);
   assign lap_inc = lap_cnt + 4'd1;

   // The DONE cycle is the only one in which commands are refused, so ready
   // comes straight off the state register.
   assign cmd.cmd_ready = (state != ST_DONE);
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;

   // NOTE: every register here is assigned with <= so all of them update from
   // the same pre-edge values; a blocking = would let later lines see new values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         q       <= 4'd0;
         lap_cnt <= 4'd0;
         target  <= 4'd0;
         busy    <= 1'b0;
         paused  <= 1'b0;
         wrap    <= 1'b0;
         done    <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         // Pulse outputs fall by default and are raised only by their event.
         wrap    <= 1'b0;
         done    <= 1'b0;
         cmd_err <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (op == OP_START) begin
                     state   <= ST_RUN;
                     q       <= 4'd0;
                     lap_cnt <= 4'd0;
                     target  <= cmd.cmd_laps;
                     busy    <= 1'b1;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end

            ST_RUN: begin
               // An accepted command replaces the increment, even at q = 8,
               // so a PAUSE/ABORT there swallows the wrap and the lap.
               if (accept) begin
                  case (op)
                     OP_PAUSE: begin
                        state  <= ST_PAUSE;
                        paused <= 1'b1;
                     end
                     OP_ABORT: begin
                        state <= ST_IDLE;
                        q     <= 4'd0;
                        busy  <= 1'b0;
                     end
                     default: cmd_err <= 1'b1;
                  endcase
               end else if (q == 4'd8) begin
                  q       <= 4'd0;
                  wrap    <= 1'b1;
                  lap_cnt <= lap_inc;
                  if (target != 4'd0 && lap_inc == target) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  q <= q + 4'd1;
               end
            end

            ST_PAUSE: begin
               if (accept) begin
                  case (op)
                     OP_RESUME: begin
                        state  <= ST_RUN;
                        paused <= 1'b0;
                     end
                     OP_ABORT: begin
                        state  <= ST_IDLE;
                        q      <= 4'd0;
                        busy   <= 1'b0;
                        paused <= 1'b0;
                     end
                     default: cmd_err <= 1'b1;
                  endcase
               end
            end

            ST_DONE: begin
               // busy is held through the DONE cycle and drops on the way
               // back to IDLE, so a run appears as one contiguous busy window.
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_9_sched.sv
// -----------------------------------------------------------------------------
// tb_counter_9_sched
//   Scenario bench for counter_9_sched. Each scenario pushes the expected
//   output vector for an edge into a queue when it drives that edge's inputs,
//   and pops/compares it one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_counter_9_sched;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_PAUSE  = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_ABORT  = 2'b11;

   typedef struct packed {
      logic [3:0] q;
      logic [3:0] lap_cnt;
      logic       busy;
      logic       paused;
      logic       wrap;
      logic       done;
      logic       cmd_err;
      logic       cmd_ready;
   } obs_t;

   typedef struct {
      bit         v;
      logic [1:0] op;
      logic [3:0] laps;
      obs_t       e;
   } row_t;

   logic       clock;
   logic       reset;
   logic [3:0] q;
   logic [3:0] lap_cnt;
   logic       busy;
   logic       paused;
   logic       wrap;
   logic       done;
   logic       cmd_err;

   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   counter_9_sched_if cmd_if ();

   counter_9_sched dut (
      .clock   (clock),
      .reset   (reset),
      .cmd     (cmd_if.slave),
      .q       (q),
      .lap_cnt (lap_cnt),
      .busy    (busy),
      .paused  (paused),
      .wrap    (wrap),
      .done    (done),
      .cmd_err (cmd_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected vector; cmd_ready is low exactly in the DONE cycle (done high).
   function automatic obs_t mk(input int qv, input int lv, input bit b,
                               input bit p, input bit w, input bit d, input bit e);
      obs_t r;
      r.q         = 4'(qv);
      r.lap_cnt   = 4'(lv);
      r.busy      = b;
      r.paused    = p;
      r.wrap      = w;
      r.done      = d;
      r.cmd_err   = e;
      r.cmd_ready = ~d;
      return r;
   endfunction

   function automatic obs_t observe();
      return {q, lap_cnt, busy, paused, wrap, done, cmd_err, cmd_if.cmd_ready};
   endfunction

   task automatic drive(input bit v, input logic [1:0] op, input logic [3:0] laps);
      cmd_if.cmd_valid = v;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_laps  = laps;
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      reset = 1'b1;
      drive(1'b1, OP_START, 4'd3);          // reset must win over a START
      cycle();
      cycle();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_held got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                  o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
      end
      drive(1'b0, OP_START, 4'd0);
      reset = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      cycle();
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_release got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                  o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
      end
   endtask

   // START laps=2 at edge 0: wraps at 9 and 18, done at 18, busy drops at 19.
   task automatic test_laps2();
      obs_t e, o;
      for (int k = 0; k <= 20; k++) begin
         drive(k == 0, OP_START, 4'd2);
         if (k < 18) exp_q.push_back(mk(k % 9, k / 9, 1, 0, k == 9, 0, 0));
         else        exp_q.push_back(mk(0, 2, k == 18, 0, k == 18, k == 18, 0));
         cycle();
         e = exp_q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL laps2 k=%0d got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                     k, o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
         end
      end
      drive(1'b0, OP_START, 4'd0);
   endtask

   // START laps=1, PAUSE accepted at edge 5 (q=4), RESUME at edge 10:
   // done lands at edge 15.
   task automatic test_pause();
      obs_t e, o;
      for (int k = 0; k <= 16; k++) begin
         if (k == 0)       drive(1'b1, OP_START, 4'd1);
         else if (k == 5)  drive(1'b1, OP_PAUSE, 4'd0);
         else if (k == 10) drive(1'b1, OP_RESUME, 4'd0);
         else              drive(1'b0, OP_START, 4'd0);
         if (k <= 4)       exp_q.push_back(mk(k, 0, 1, 0, 0, 0, 0));
         else if (k <= 9)  exp_q.push_back(mk(4, 0, 1, 1, 0, 0, 0));
         else if (k == 10) exp_q.push_back(mk(4, 0, 1, 0, 0, 0, 0));
         else if (k <= 14) exp_q.push_back(mk(k - 6, 0, 1, 0, 0, 0, 0));
         else if (k == 15) exp_q.push_back(mk(0, 1, 1, 0, 1, 1, 0));
         else              exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
         cycle();
         e = exp_q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL pause k=%0d got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                     k, o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
         end
      end
      drive(1'b0, OP_START, 4'd0);
   endtask

   // START laps=3, ABORT accepted at edge 18 while q=8 in lap 2.
   task automatic test_abort();
      obs_t e, o;
      for (int k = 0; k <= 19; k++) begin
         if (k == 0)       drive(1'b1, OP_START, 4'd3);
         else if (k == 18) drive(1'b1, OP_ABORT, 4'd0);
         else              drive(1'b0, OP_START, 4'd0);
         if (k < 18) exp_q.push_back(mk(k % 9, k / 9, 1, 0, k == 9, 0, 0));
         else        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
         cycle();
         e = exp_q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL abort k=%0d got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                     k, o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
         end
      end
   endtask

   // Starts in IDLE with q=0, lap_cnt=1 (left by test_abort).
   task automatic test_illegal();
      obs_t e, o;
      row_t tbl[17];
      tbl[0]  = '{1'b1, OP_RESUME, 4'd0, mk(0, 1, 0, 0, 0, 0, 1)};
      tbl[1]  = '{1'b0, OP_START,  4'd0, mk(0, 1, 0, 0, 0, 0, 0)};
      tbl[2]  = '{1'b1, OP_ABORT,  4'd0, mk(0, 1, 0, 0, 0, 0, 1)};
      tbl[3]  = '{1'b1, OP_PAUSE,  4'd0, mk(0, 1, 0, 0, 0, 0, 1)};
      tbl[4]  = '{1'b0, OP_START,  4'd0, mk(0, 1, 0, 0, 0, 0, 0)};
      tbl[5]  = '{1'b1, OP_START,  4'd2, mk(0, 0, 1, 0, 0, 0, 0)};
      tbl[6]  = '{1'b0, OP_START,  4'd0, mk(1, 0, 1, 0, 0, 0, 0)};
      tbl[7]  = '{1'b0, OP_START,  4'd0, mk(2, 0, 1, 0, 0, 0, 0)};
      tbl[8]  = '{1'b1, OP_START,  4'd5, mk(2, 0, 1, 0, 0, 0, 1)};
      tbl[9]  = '{1'b0, OP_START,  4'd0, mk(3, 0, 1, 0, 0, 0, 0)};
      tbl[10] = '{1'b1, OP_PAUSE,  4'd0, mk(3, 0, 1, 1, 0, 0, 0)};
      tbl[11] = '{1'b1, OP_PAUSE,  4'd0, mk(3, 0, 1, 1, 0, 0, 1)};
      tbl[12] = '{1'b1, OP_START,  4'd0, mk(3, 0, 1, 1, 0, 0, 1)};
      tbl[13] = '{1'b1, OP_RESUME, 4'd0, mk(3, 0, 1, 0, 0, 0, 0)};
      tbl[14] = '{1'b1, OP_RESUME, 4'd0, mk(3, 0, 1, 0, 0, 0, 1)};
      tbl[15] = '{1'b0, OP_START,  4'd0, mk(4, 0, 1, 0, 0, 0, 0)};
      tbl[16] = '{1'b1, OP_ABORT,  4'd0, mk(0, 0, 0, 0, 0, 0, 0)};
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].laps);
         exp_q.push_back(tbl[i].e);
         cycle();
         e = exp_q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL illegal row=%0d got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                     i, o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
         end
      end
      drive(1'b0, OP_START, 4'd0);
   endtask

   // laps=0 free-run for 160 edges (lap_cnt wraps 15 -> 0 at edge 144),
   // then ABORT at edge 161.
   task automatic test_free_run();
      obs_t e, o;
      for (int k = 0; k <= 161; k++) begin
         if (k == 0)        drive(1'b1, OP_START, 4'd0);
         else if (k == 161) drive(1'b1, OP_ABORT, 4'd0);
         else               drive(1'b0, OP_START, 4'd0);
         if (k <= 160) exp_q.push_back(mk(k % 9, (k / 9) % 16, 1, 0, k > 0 && k % 9 == 0, 0, 0));
         else          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
         cycle();
         e = exp_q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL free_run k=%0d got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                     k, o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
         end
      end
      drive(1'b0, OP_START, 4'd0);
   endtask

   // START offered during the DONE cycle is refused, held, and taken at the
   // IDLE edge after it.
   task automatic test_back_to_back();
      obs_t e, o;
      for (int k = 0; k <= 21; k++) begin
         drive(k == 0 || k == 10 || k == 11, OP_START, 4'd1);
         if (k < 9)        exp_q.push_back(mk(k, 0, 1, 0, 0, 0, 0));
         else if (k == 9)  exp_q.push_back(mk(0, 1, 1, 0, 1, 1, 0));
         else if (k == 10) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
         else if (k < 20)  exp_q.push_back(mk(k - 11, 0, 1, 0, 0, 0, 0));
         else if (k == 20) exp_q.push_back(mk(0, 1, 1, 0, 1, 1, 0));
         else              exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
         cycle();
         e = exp_q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back k=%0d got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                     k, o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
         end
      end
      drive(1'b0, OP_START, 4'd0);
   endtask

   // Reset at q=5, lap_cnt=1 (edge 15), then a fresh laps=1 run from edge 17.
   task automatic test_reset_mid_run();
      obs_t e, o;
      for (int k = 0; k <= 27; k++) begin
         reset = (k == 15);
         if (k == 0)       drive(1'b1, OP_START, 4'd3);
         else if (k == 17) drive(1'b1, OP_START, 4'd1);
         else              drive(1'b0, OP_START, 4'd0);
         if (k <= 14)      exp_q.push_back(mk(k % 9, k / 9, 1, 0, k == 9, 0, 0));
         else if (k <= 16) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
         else if (k <= 25) exp_q.push_back(mk(k - 17, 0, 1, 0, 0, 0, 0));
         else if (k == 26) exp_q.push_back(mk(0, 1, 1, 0, 1, 1, 0));
         else              exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
         cycle();
         e = exp_q.pop_front();
         o = observe();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_mid k=%0d got q=%0d lap=%0d flags=%b exp q=%0d lap=%0d flags=%b",
                     k, o.q, o.lap_cnt, o[5:0], e.q, e.lap_cnt, e[5:0]);
         end
      end
      reset = 1'b0;
      drive(1'b0, OP_START, 4'd0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, OP_START, 4'd0);
      test_reset();
      test_laps2();
      test_pause();
      test_abort();
      test_illegal();
      test_free_run();
      test_back_to_back();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
